// File: rtl/demux_1t4_seq_pkg.sv
// Shared constants for the sequential 1-to-4 RK4 slope distributor:
// FSM state encoding and the RK4 slope weights.
package demux_1t4_seq_pkg;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_SUM  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int W0 = 1;
  localparam int W1 = 2;
  localparam int W2 = 2;
  localparam int W3 = 1;

  localparam int NUM_SLOTS = 4;

  function automatic int rk4_weight(input int idx);
    case (idx)
      0:       return W0;
      1:       return W1;
      2:       return W2;
      default: return W3;
    endcase
  endfunction

endpackage

// File: rtl/rk4_wsum.sv
// Combinational RK4 weighted sum k0 + 2*k1 + 2*k2 + k3; three guard bits
// cover the worst case 6 * (-2^(n-1)), so the result cannot overflow.
module rk4_wsum
  import demux_1t4_seq_pkg::*;
#(
  parameter int n = 4
) (
  input  logic signed [n-1:0] k0,
  input  logic signed [n-1:0] k1,
  input  logic signed [n-1:0] k2,
  input  logic signed [n-1:0] k3,
  output logic signed [n+2:0] wsum
);

  logic signed [n-1:0] k    [NUM_SLOTS];
  logic signed [n+2:0] term [NUM_SLOTS];

  assign k[0] = k0;
  assign k[1] = k1;
  assign k[2] = k2;
  assign k[3] = k3;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_term
    localparam logic signed [n+2:0] WK = (n+3)'(rk4_weight(gi));
    assign term[gi] = (n+3)'(k[gi]) * WK;
  end

  assign wsum = term[0] + term[1] + term[2] + term[3];

endmodule

// File: rtl/demux_1t4_seq.sv
// Captures four consecutive words of a valid/ready stream into slots d0..d3,
// then publishes the frame with its RK4 weighted sum until acknowledged.
module demux_1t4_seq
  import demux_1t4_seq_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic signed [n-1:0] d_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [n-1:0] d0,
  output logic signed [n-1:0] d1,
  output logic signed [n-1:0] d2,
  output logic signed [n-1:0] d3,
  output logic        [1:0]   slot,
  output logic signed [n+2:0] wsum,
  output logic                out_valid,
  input  logic                out_ack
);

  logic [1:0]          state_reg, state_next;
  logic [1:0]          slot_reg;
  logic signed [n-1:0] d_reg [NUM_SLOTS];
  logic signed [n+2:0] wsum_reg, wsum_comb;
  logic                out_valid_reg;
  logic                xfer;
  logic [NUM_SLOTS-1:0] wr_en;

  assign xfer = in_valid & in_ready;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_wr_en
    assign wr_en[gi] = xfer & (slot_reg == 2'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_FILL;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = ST_FILL;
    end else begin
      case (state_reg)
        ST_FILL: if (xfer && slot_reg == 2'd3) state_next = ST_SUM;
        ST_SUM:  state_next = ST_HOLD;
        ST_HOLD: if (out_ack) state_next = ST_FILL;
        default: state_next = ST_FILL;
      endcase
    end
  end

  // rst_n gates in_ready so the stream stalls while reset is held
  always_comb begin
    in_ready = rst_n & (state_reg == ST_FILL) & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg      <= 2'd0;
      wsum_reg      <= '0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) d_reg[i] <= '0;
    end else if (clr) begin
      slot_reg      <= 2'd0;
      wsum_reg      <= '0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) d_reg[i] <= '0;
    end else begin
      if (xfer) slot_reg <= slot_reg + 2'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en[i]) d_reg[i] <= d_in;
      end
      if (state_reg == ST_SUM) begin
        wsum_reg      <= wsum_comb;
        out_valid_reg <= 1'b1;
      end else if (state_reg == ST_HOLD && out_ack) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  rk4_wsum #(.n(n)) u_rk4_wsum (
    .k0   (d_reg[0]),
    .k1   (d_reg[1]),
    .k2   (d_reg[2]),
    .k3   (d_reg[3]),
    .wsum (wsum_comb)
  );

  assign d0        = d_reg[0];
  assign d1        = d_reg[1];
  assign d2        = d_reg[2];
  assign d3        = d_reg[3];
  assign slot      = slot_reg;
  assign wsum      = wsum_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_demux_1t4_seq.sv
// Directed bench for demux_1t4_seq: fill/sum/hold/ack, gaps, clear and async reset.
module tb_demux_1t4_seq;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr = 1'b0;
  logic signed [N-1:0] d_in = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [N-1:0] d0, d1, d2, d3;
  logic        [1:0]   slot;
  logic signed [N+2:0] wsum;
  logic                out_valid;
  logic                out_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1t4_seq #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .slot      (slot),
    .wsum      (wsum),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four words back-to-back with in_valid held high; in_valid left at 0 afterwards.
  task automatic feed4(input int a, input int b, input int c, input int d);
    int w[4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      d_in = N'(w[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    int gap_w[4];
    int gap_s[4];

    // 1. reset, then 1,2,3,4 back-to-back
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_wsum", int'(wsum), 0);
    chk("rst_slot", int'(slot), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      d_in = N'(i + 1);
      in_valid = 1'b1;
      chk("t1_ready_before_accept", int'(in_ready), 1);
      tick();
    end
    chk("t1_ready_after_4th", int'(in_ready), 0);
    chk("t1_ovalid_edge1", int'(out_valid), 0);
    chk("t1_slot_wrap", int'(slot), 0);
    tick();
    chk("t1_ovalid_edge2", int'(out_valid), 1);
    chk("t1_wsum", int'(wsum), 15);
    chk("t1_d0", int'(d0), 1);
    chk("t1_d1", int'(d1), 2);
    chk("t1_d2", int'(d2), 3);
    chk("t1_d3", int'(d3), 4);
    chk("t1_ready_hold", int'(in_ready), 0);
    in_valid = 1'b0;
    ack();
    chk("t1_ovalid_after_ack", int'(out_valid), 0);
    chk("t1_ready_after_ack", int'(in_ready), 1);

    // 2. extreme values
    feed4(-8, -8, -8, -8);
    tick();
    chk("t2_wsum_neg", int'(wsum), -48);
    chk("t2_wsum_bits", int'($unsigned(wsum)), 7'b1010000);
    ack();
    feed4(7, 7, 7, 7);
    tick();
    chk("t2_wsum_pos", int'(wsum), 42);
    ack();

    // 3. gapped valid: 1 on / 2 off; 3 + 2*(-1) + 2*0 + 5 = 6
    gap_w = '{3, -1, 0, 5};
    gap_s = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      chk("t3_slot_before", int'(slot), i);
      d_in = N'(gap_w[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      d_in = N'(-7);
      tick();
      chk("t3_slot_gap", int'(slot), gap_s[i]);
      tick();
      chk("t3_slot_gap2", int'(slot), gap_s[i]);
    end
    chk("t3_ovalid", int'(out_valid), 1);
    chk("t3_wsum", int'(wsum), 6);
    chk("t3_d1", int'(d1), -1);

    // 4. hold 10 cycles with in_valid high and no ack
    in_valid = 1'b1;
    d_in = N'(-3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_ovalid", int'(out_valid), 1);
      chk("t4_hold_ready", int'(in_ready), 0);
      chk("t4_hold_d0", int'(d0), 3);
      chk("t4_hold_wsum", int'(wsum), 6);
    end
    in_valid = 1'b0;
    ack();
    chk("t4_ovalid_cleared", int'(out_valid), 0);
    chk("t4_d0_retained", int'(d0), 3);
    d_in = N'(-3);
    in_valid = 1'b1;
    tick();
    chk("t4_next_word_d0", int'(d0), -3);
    chk("t4_slot_1", int'(slot), 1);

    // 5. second word, then clr with a concurrent valid word
    d_in = N'(2);
    tick();
    chk("t5_slot_2", int'(slot), 2);
    clr = 1'b1;
    d_in = N'(6);
    #1;
    chk("t5_ready_clr", int'(in_ready), 0);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("t5_slot_clr", int'(slot), 0);
    chk("t5_d0_clr", int'(d0), 0);
    chk("t5_d1_clr", int'(d1), 0);
    chk("t5_d2_dropped", int'(d2), 0);
    feed4(2, 0, -1, 4);
    tick();
    chk("t5_ovalid", int'(out_valid), 1);
    chk("t5_wsum", int'(wsum), 4);
    chk("t5_d3", int'(d3), 4);
    ack();

    // 6. async reset while the frame is in SUM
    feed4(1, 1, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ovalid_async", int'(out_valid), 0);
    chk("t6_wsum_async", int'(wsum), 0);
    chk("t6_d0_async", int'(d0), 0);
    chk("t6_d3_async", int'(d3), 0);
    chk("t6_ready_async", int'(in_ready), 0);
    tick();
    tick();
    chk("t6_ovalid_in_rst", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_ovalid_after_rst", int'(out_valid), 0);
    chk("t6_slot_after_rst", int'(slot), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
